// File: rtl/seq_restoring_divider_pkg.sv
// Shared definitions for the sequential restoring divider: FSM state encodings
// and the iteration-counter width helper.
package seq_restoring_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that spans 2n iterations, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (2 * n > 1) ? $clog2(2 * n) : 1;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_trial_sub.sv
// Trial subtraction for one restoring-division step: (N+1)-bit minuend minus
// the N-bit divisor, giving the low N bits of the difference and a borrow flag.
module div_trial_sub
  import seq_restoring_divider_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N:0]   minuend,
  input  logic [N-1:0] subtrahend,
  output logic [N-1:0] difference,
  output logic         borrow
);

  // A true borrow: a zero divisor can never borrow, so every trial succeeds.
  // For a nonzero divisor this equals the top bit of the (N+1)-bit difference.
  always_comb begin
    borrow     = (minuend < {1'b0, subtrahend});
    difference = minuend[N-1:0] - subtrahend;
  end

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit
// per clock. Define DIV_ZERO_FAST_EN to add div_by_zero and a one-cycle zero-divisor path.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder
`ifdef DIV_ZERO_FAST_EN
  ,
  output logic           div_by_zero
`endif
);

  localparam int CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(2 * N - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     p;
  logic [2*N-1:0]   q;
  logic [N-1:0]     dvs;

  logic             accept;
  logic [N:0]       minuend;
  logic [N-1:0]     diff;
  logic             borrow;
  logic [N-1:0]     p_next;
  logic [2*N-1:0]   q_next;

  assign accept  = start && ((state == IDLE) || (state == DONE));
  assign minuend = {p, q[2*N-1]};

  div_trial_sub #(.N(N)) u_trial (
    .minuend    (minuend),
    .subtrahend (dvs),
    .difference (diff),
    .borrow     (borrow)
  );

  // On a failed trial the shifted value is below the divisor, so N bits hold it.
  assign p_next = borrow ? minuend[N-1:0] : diff;
  assign q_next = {q[2*N-2:0], ~borrow};

  // Datapath registers: loaded on accept, stepped while running.
  always_ff @(posedge clk) begin
    if (accept) begin
      p   <= '0;
      q   <= dividend;
      dvs <= divisor;
    end else if (state == RUN) begin
      p <= p_next;
      q <= q_next;
    end
  end

  // Control FSM and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
`ifdef DIV_ZERO_FAST_EN
      div_by_zero <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            cnt <= '0;
`ifdef DIV_ZERO_FAST_EN
            div_by_zero <= 1'b0;
            if (divisor == '0) begin
              state       <= DONE;
              done        <= 1'b1;
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[N-1:0];
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
`else
            state <= RUN;
            busy  <= 1'b1;
`endif
          end else if (state == DONE) begin
            state <= IDLE;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_ITER) begin
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            quotient  <= q_next;
            remainder <= p_next;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Scoreboard bench for seq_restoring_divider (N=4); honours DIV_ZERO_FAST_EN when defined.
module tb_seq_restoring_divider;

  localparam int N = 4;

  typedef struct packed {
    logic [2*N-1:0] q;
    logic [N-1:0]   r;
    logic           dbz;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           dbz_out;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder)
`ifdef DIV_ZERO_FAST_EN
    ,
    .div_by_zero (dbz_out)
`endif
  );

`ifndef DIV_ZERO_FAST_EN
  assign dbz_out = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expected result.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got q=%0d r=%0d, expected no result", quotient, remainder);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("quotient", 32'(quotient), 32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
`ifdef DIV_ZERO_FAST_EN
        check("div_by_zero", 32'(dbz_out), 32'(e.dbz));
`endif
      end
    end
  end

  // Called at a negedge with the DUT ready; returns #1 after the accepting edge.
  task automatic send(input logic [2*N-1:0] a, input logic [N-1:0] b,
                      input logic [2*N-1:0] eq, input logic [N-1:0] er, input bit push);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) begin
      e.q = eq;
      e.r = er;
`ifdef DIV_ZERO_FAST_EN
      e.dbz = (b == '0);
`else
      e.dbz = 1'b0;
`endif
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = a ^ 8'h5A;
    divisor  = b ^ 4'hF;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 20);
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", n);
    end
  endtask

  // Per-cycle busy/done after an accept: busy for run cycles, then one done.
  task automatic check_timing(input int run);
    for (int i = 1; i <= run + 1; i++) begin
      @(negedge clk);
      check($sformatf("busy_done_cycle%0d", i), 32'({busy, done}),
            32'({(i <= run), (i == run + 1)}));
    end
  endtask

  initial begin
    logic [2*N-1:0] a;
    logic [N-1:0]   b;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_quotient", 32'(quotient), 0);
    check("reset_remainder", 32'(remainder), 0);
    check("reset_dbz", 32'(dbz_out), 0);
    rst = 1'b0;
    @(negedge clk);

    // 200/7 with latency profile
    send(8'd200, 4'd7, 8'd28, 4'd4, 1'b1);
    check_timing(2 * N);

    // Boundaries, issued back-to-back from the DONE cycle
    send(8'd255, 4'd1, 8'd255, 4'd0, 1'b1);
    wait_done();
    send(8'd13, 4'd15, 8'd0, 4'd13, 1'b1);
    wait_done();
    send(8'd0, 4'd9, 8'd0, 4'd0, 1'b1);
    wait_done();

    // Divide by zero
    send(8'd100, 4'd0, 8'd255, 4'd4, 1'b1);
`ifdef DIV_ZERO_FAST_EN
    check_timing(0);
`else
    check_timing(2 * N);
`endif

    // Start while busy is ignored; start in DONE is accepted
    send(8'd60, 4'd5, 8'd12, 4'd0, 1'b1);
    repeat (2) @(negedge clk);
    send(8'd99, 4'd3, 8'd0, 4'd0, 1'b0);
    check("busy_after_ignored_start", 32'(busy), 1);
    wait_done();
    send(8'd99, 4'd3, 8'd33, 4'd0, 1'b1);
    wait_done();

    // Reset mid-run aborts with no done
    send(8'd77, 4'd3, 8'd0, 4'd0, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_quotient", 32'(quotient), 0);
    check("abort_remainder", 32'(remainder), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    send(8'd250, 4'd11, 8'd22, 4'd8, 1'b1);
    wait_done();

    // Sweep with nonzero divisors
    for (int i = 0; i < 2000; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(1, 15));
      send(a, b, a / 8'(b), 4'(a % 8'(b)), 1'b1);
      wait_done();
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
